// File: rtl/mem_port_arbiter_if.sv
// Bundle of every client-side and bus-side handshake signal of the memory
// port arbiter. The arbiter connects through the slave modport; the fetch
// stage, memory stage and external bus (or a bench) use the master modport.
interface mem_port_arbiter_if;
    // instruction fetch client
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    // memory stage client
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    // shared downstream port
    logic        oreq_valid;
    logic [63:0] oreq_addr;
    logic [2:0]  oreq_size;
    logic [7:0]  oreq_strobe;
    logic [63:0] oreq_data;
    logic        oresp_addr_ok;
    logic        oresp_data_ok;
    logic [63:0] oresp_data;

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        output oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data,
        input  oresp_addr_ok, oresp_data_ok, oresp_data
    );

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        input  oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data,
        output oresp_addr_ok, oresp_data_ok, oresp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one downstream memory port between instruction
// fetch (I) and the memory stage (D). One transaction in flight; D wins ties
// so the memory-stage stall clears first. A client that drops its valid
// after being granted (pipeline flush) has its transaction completed
// downstream, but the response is never returned upstream.
//
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT
// consecutive D grants while I is waiting, the next grant goes to I.
// Without the macro D has strict priority and no counter exists.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    // Downstream size code used for a 4-byte instruction fetch.
    localparam logic [2:0] MSIZE4 = 3'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } state_t;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    state_t      state_q, state_d;
    logic        abort_q, abort_d;
    logic        oreq_valid_q, oreq_valid_d;
    logic [63:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] wdata_q, wdata_d;

    logic i_act, d_act, in_req;
    logic client_valid, abort_now;
    logic addr_hs, done;
    logic grant_i, grant_d, i_forced;

    // Owner of the in-flight transaction and whether it is still wanted.
    always_comb begin
        i_act        = (state_q == REQ_I) || (state_q == WAIT_I);
        d_act        = (state_q == REQ_D) || (state_q == WAIT_D);
        in_req       = (state_q == REQ_I) || (state_q == REQ_D);
        client_valid = i_act ? bus.ireq_valid : bus.dreq_valid;
        // A drop in the completing cycle itself also counts as a flush.
        abort_now    = abort_q || !client_valid;
        addr_hs      = in_req && bus.oresp_addr_ok;
        done         = (addr_hs || (state_q == WAIT_I) || (state_q == WAIT_D))
                       && bus.oresp_data_ok;
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    // Count D grants taken while I is waiting; any I grant or I going idle resets it.
    always_comb begin
        starve_d = starve_q;
        if (!bus.ireq_valid) begin
            starve_d = '0;
        end else if (grant_i) begin
            starve_d = '0;
        end else if (grant_d && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // I takes the port once D has had its run of back-to-back grants.
    always_comb begin
        i_forced = bus.ireq_valid && (starve_q == LIMIT);
    end
`else
    // Strict D priority: I is never forced ahead of D.
    always_comb begin
        i_forced = 1'b0;
    end
`endif

    // Grant decision is only ever made from IDLE, never in a completing cycle.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            if (bus.dreq_valid && !i_forced) begin
                grant_d = 1'b1;
            end else if (bus.ireq_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    // Next-state and request-register logic.
    always_comb begin
        state_d      = state_q;
        abort_d      = abort_q;
        oreq_valid_d = oreq_valid_q;
        addr_d       = addr_q;
        size_d       = size_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (grant_d) begin
                    state_d      = REQ_D;
                    oreq_valid_d = 1'b1;
                    addr_d       = bus.dreq_addr;
                    size_d       = bus.dreq_size;
                    strobe_d     = bus.dreq_strobe;
                    wdata_d      = bus.dreq_data;
                end else if (grant_i) begin
                    // fetch is always a 4-byte read
                    state_d      = REQ_I;
                    oreq_valid_d = 1'b1;
                    addr_d       = bus.ireq_addr;
                    size_d       = MSIZE4;
                    strobe_d     = 8'h00;
                    wdata_d      = 64'h0;
                end
            end
            REQ_I, REQ_D: begin
                if (bus.oresp_addr_ok) begin
                    oreq_valid_d = 1'b0;
                    if (bus.oresp_data_ok) begin
                        state_d = IDLE;
                    end else begin
                        state_d = (state_q == REQ_I) ? WAIT_I : WAIT_D;
                    end
                end
            end
            WAIT_I, WAIT_D: begin
                if (bus.oresp_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                oreq_valid_d = 1'b0;
            end
        endcase

        // The abort flag tracks the owner while a transaction is open.
        if (i_act || d_act) begin
            abort_d = done ? 1'b0 : abort_now;
        end
    end

    // State and request registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            abort_q      <= 1'b0;
            oreq_valid_q <= 1'b0;
            addr_q       <= 64'h0;
            size_q       <= 3'd0;
            strobe_q     <= 8'h00;
            wdata_q      <= 64'h0;
        end else begin
            state_q      <= state_d;
            abort_q      <= abort_d;
            oreq_valid_q <= oreq_valid_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
        end
    end

    // Downstream request comes only from registers.
    always_comb begin
        bus.oreq_valid  = oreq_valid_q;
        bus.oreq_addr   = addr_q;
        bus.oreq_size   = size_q;
        bus.oreq_strobe = strobe_q;
        bus.oreq_data   = wdata_q;
    end

    // Upstream responses: pulses follow the bus combinationally, masked for
    // aborted transactions; data is zero outside its data_ok cycle.
    always_comb begin
        bus.iresp_addr_ok = addr_hs && i_act && !abort_now;
        bus.dresp_addr_ok = addr_hs && d_act && !abort_now;
        bus.iresp_data_ok = done && i_act && !abort_now;
        bus.dresp_data_ok = done && d_act && !abort_now;
        bus.iresp_data    = 32'h0;
        bus.dresp_data    = 64'h0;
        if (bus.iresp_data_ok) begin
            bus.iresp_data = addr_q[2] ? bus.oresp_data[63:32] : bus.oresp_data[31:0];
        end
        if (bus.dresp_data_ok) begin
            bus.dresp_data = bus.oresp_data;
        end
    end

endmodule
